cdc_event_sched: RTL and testbench
==================================

Name: cdc_event_sched

Overview:
- Schedules single-cycle event pulses from NCH requesters in the aclk domain across one shared toggle-based crossing into the bclk domain.
- Each channel has a small pending counter, so bursts are not lost while the crossing is busy.
- A round-robin arbiter picks one channel at a time. The channel ID is held stable until a return-acknowledge toggle confirms delivery.
- Sits between local event sources (strobes, FIFO flags) and a slower or faster consumer clock domain; the consumer clock can be enabled or stalled.

Parameters:
- NCH, 4, number of requester channels (2..16).
- CNTW, 3, pending-counter width per channel; saturates at 2^CNTW-1.
- IDW, $clog2(NCH), channel ID width (derived, not overridden).

Ports:
- aclk  in  1  source clock.
- arst  in  1  source reset, synchronous, active-high, on aclk.
- bclk  in  1  destination clock.
- brst  in  1  destination reset, synchronous, active-high, on bclk.
- req  in  NCH  aclk; one-cycle event pulse per channel; several bits may be high in the same cycle.
- ovf  out  NCH  aclk; sticky per channel; set when an event is dropped at saturation.
- ovf_clr  in  1  aclk; clears all ovf bits.
- busy  out  1  aclk; high while an event is in flight (WAIT state).
- boe  in  1  bclk; output enable; delivery is deferred while low.
- b_valid  out  1  bclk; one-cycle pulse per delivered event.
- b_id  out  IDW  bclk; channel of the event; valid when b_valid is high.

Behaviour:
- Reset, aclk domain (arst): all counters 0, ovf 0, FSM in IDLE, t=0, rr pointer 0, id_q 0, ack synchronizers 0, busy 0.
- Reset, bclk domain (brst): s0, s1, s2 = 0, ack toggle 0, b_valid 0, b_id 0.
- Counter rules, per channel, evaluated each aclk cycle:
  - req only: cnt+1.
  - grant only: cnt-1.
  - req and grant together: cnt unchanged.
  - req with cnt at max and no grant: cnt unchanged, ovf set.
- ovf_clr: clears ovf. If ovf_clr and a set condition coincide, the set wins.
- FSM, aclk domain:
  - IDLE: if any cnt != 0, grant the first nonzero channel at or after the rr pointer, wrapping. In the same cycle: id_q <= winner, t <= ~t, winner's cnt decrements, rr pointer <= winner+1 mod NCH, go to WAIT. If all counters are 0, stay in IDLE.
  - WAIT: busy=1; id_q and t held constant. Return ack is double-flopped into aclk as ack_s1. When ack_s1 == t, go to IDLE. A new grant can occur on the next cycle.
- bclk domain:
  - s0 <= t on every bclk cycle.
  - s1 <= s0 and s2 <= s1 only when boe=1.
  - When s1 != s2 and boe=1: register b_valid=1 and b_id <= id_q, which is quasi-static and safe to sample. In the same cycle, ack <= s1.
  - Otherwise b_valid=0.
  - While boe=0, a pending transition is held, not lost.
- Latency:
  - Request to grant: 1 aclk cycle.
  - Grant to b_valid: 3 enabled bclk cycles.
  - Round trip: about 3 bclk + 3 aclk cycles per event.
  - Throughput: at most one event per round trip.
- Boundary cases:
  - A req on the channel currently in flight only increments its counter.
  - arst during WAIT abandons the in-flight event. brst during WAIT discards it as well.
  - Both resets are required together for a coherent restart. A lone brst with t=1 produces one spurious delivery of id_q; this is accepted and documented.
  - NCH=1: arbiter is trivial; b_id is width 1 and tied to 0.

Optional Feature:
- Macro: CDC_EVENT_SCHED_PRIO_EN.
- When defined: fixed priority, lowest channel index wins; the rr pointer is removed.
- When undefined: round-robin as described above.
- All other timing is identical in both builds.

Decomposition:
- Package cdc_event_sched_pkg: FSM state enum (ST_IDLE, ST_WAIT) and default constants NCH_DEF=4, CNTW_DEF=3.
- Sub-module evt_rr_arb: request vector and pointer in; one-hot grant and encoded ID out; combinational. Fixed-priority mode is selected inside it by the macro.
- Counters, FSM and both synchronizer sets stay in the top module.

Test Plan:
- Single event: req[2] pulse, boe=1, aclk=bclk/2 period -> exactly one b_valid with b_id=2 and busy low afterward. Delivery occurs 3 bclk cycles after grant.
- Burst: req[1] high for 5 consecutive cycles with CNTW=3 -> five b_valid pulses, all b_id=1, ovf[1]=0.
- Saturation: 9 req[0] pulses while boe=0 -> cnt[0]=7, ovf[0]=1 after the 9th pulse. Raise boe -> 8 deliveries total (1 in flight + 7).
- Round robin: req=4'b1111 once -> b_id sequence 0,1,2,3.
  - Repeat with the macro defined and channels 0 and 3 re-requested continuously -> only 0 and 3 are delivered, with 0 favoured.
- boe stall: boe=0 for 50 bclk cycles mid-flight -> no b_valid during the stall. One b_valid occurs within 3 bclk cycles after boe returns high, and busy remains 1 until then.
- Reset mid-flight: assert arst and brst together during WAIT -> all outputs at reset values, no delivery afterward, and a subsequent req[3] is delivered normally.

Source files
------------

// File: rtl/cdc_event_sched_pkg.sv
// Shared types and defaults for the cdc_event_sched block.
// Optional build macro: CDC_EVENT_SCHED_PRIO_EN (fixed-priority arbitration).
package cdc_event_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int NCH_DEF  = 4;
    localparam int CNTW_DEF = 3;

    // Channel ID width; a single channel still gets a 1-bit ID.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_event_sched_arb.sv
// evt_rr_arb: combinational channel picker for cdc_event_sched.
// Round-robin from i_ptr by default; with CDC_EVENT_SCHED_PRIO_EN defined the
// pointer port disappears and the lowest requesting index always wins.
module evt_rr_arb
    import cdc_event_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    localparam int IDW = id_w(NCH)
) (
    input  logic [NCH-1:0] i_req,
`ifndef CDC_EVENT_SCHED_PRIO_EN
    input  logic [IDW-1:0] i_ptr,
`endif
    output logic [NCH-1:0] o_gnt,
    output logic [IDW-1:0] o_id,
    output logic           o_any
);

    // Scan channels in priority order and take the first requester.
    always_comb begin
        int w_idx;
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NCH; k++) begin
`ifdef CDC_EVENT_SCHED_PRIO_EN
            w_idx = k;
`else
            w_idx = (int'(i_ptr) + k) % NCH;
`endif
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_id         = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/cdc_event_sched.sv
// cdc_event_sched: per-channel event counters in aclk, one arbitrated event at
// a time carried to bclk over a toggle (t) with a toggle acknowledge back.
// Optional build macro: CDC_EVENT_SCHED_PRIO_EN (fixed priority, no rr pointer).
// Both resets should be applied together; a lone brst while t=1 re-delivers
// id_q once, which is accepted behaviour.
module cdc_event_sched
    import cdc_event_sched_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int CNTW = CNTW_DEF,
    localparam int IDW = id_w(NCH)
) (
    input  logic           aclk,
    input  logic           arst,
    input  logic           bclk,
    input  logic           brst,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] ovf,
    input  logic           ovf_clr,
    output logic           busy,
    input  logic           boe,
    output logic           b_valid,
    output logic [IDW-1:0] b_id
);

    localparam logic [CNTW-1:0] CMAX = '1;

    // aclk domain
    state_t                     r_state, w_state_nxt;
    logic [NCH-1:0][CNTW-1:0]   r_cnt;
    logic [NCH-1:0]             r_ovf;
    logic [NCH-1:0]             w_nz, w_gnt_raw, w_gnt;
    logic [IDW-1:0]             w_win, r_id_q;
    logic                       w_any, w_grant_en;
    logic                       r_t, r_ack_s0, r_ack_s1;
`ifndef CDC_EVENT_SCHED_PRIO_EN
    logic [IDW-1:0]             r_rr;
`endif

    // bclk domain
    logic                       r_s0, r_s1, r_s2, r_back;
    logic                       r_b_valid;
    logic [IDW-1:0]             r_b_id;

    // A channel competes whenever it has at least one pending event.
    always_comb begin
        w_nz = '0;
        for (int i = 0; i < NCH; i++) w_nz[i] = |r_cnt[i];
    end

    evt_rr_arb #(.NCH(NCH)) u_arb (
        .i_req (w_nz),
`ifndef CDC_EVENT_SCHED_PRIO_EN
        .i_ptr (r_rr),
`endif
        .o_gnt (w_gnt_raw),
        .o_id  (w_win),
        .o_any (w_any)
    );

    assign w_gnt = w_grant_en ? w_gnt_raw : '0;

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (arst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM next state: launch when something is pending, return on matching ack.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)           w_state_nxt = ST_WAIT;
            ST_WAIT: if (r_ack_s1 == r_t) w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: grant only from IDLE, busy for the whole flight.
    always_comb begin
        w_grant_en = (r_state == ST_IDLE) && w_any;
        busy       = (r_state == ST_WAIT);
    end

    // Launch: latch the winner, flip the toggle, advance the rr pointer.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_t    <= 1'b0;
            r_id_q <= '0;
`ifndef CDC_EVENT_SCHED_PRIO_EN
            r_rr   <= '0;
`endif
        end else if (w_grant_en) begin
            r_t    <= ~r_t;
            r_id_q <= w_win;
`ifndef CDC_EVENT_SCHED_PRIO_EN
            r_rr   <= (w_win == IDW'(NCH - 1)) ? '0 : w_win + 1'b1;
`endif
        end
    end

    // Pending counters and sticky overflow; a new overflow beats ovf_clr.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case ({req[i], w_gnt[i]})
                    2'b10:   if (r_cnt[i] != CMAX) r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: ;
                endcase
                if (req[i] && !w_gnt[i] && (r_cnt[i] == CMAX)) r_ovf[i] <= 1'b1;
                else if (ovf_clr)                              r_ovf[i] <= 1'b0;
            end
        end
    end

    assign ovf = r_ovf;

    // Bring the bclk acknowledge toggle back into aclk.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_ack_s0 <= 1'b0;
            r_ack_s1 <= 1'b0;
        end else begin
            r_ack_s0 <= r_back;
            r_ack_s1 <= r_ack_s0;
        end
    end

    // Destination side: sync t, detect an edge only while enabled, so a stalled
    // transition stays parked in s0/s1 until boe returns. id_q is stable here.
    always_ff @(posedge bclk) begin
        if (brst) begin
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_back    <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_id    <= '0;
        end else begin
            r_s0      <= r_t;
            r_b_valid <= 1'b0;
            if (boe) begin
                r_s1 <= r_s0;
                r_s2 <= r_s1;
                if (r_s1 != r_s2) begin
                    r_b_valid <= 1'b1;
                    r_b_id    <= r_id_q;
                    r_back    <= r_s1;
                end
            end
        end
    end

    assign b_valid = r_b_valid;

    if (NCH > 1) begin : g_id
        assign b_id = r_b_id;
    end else begin : g_id1
        assign b_id = '0;
    end

endmodule

// File: tb/tb_cdc_event_sched.sv
// Scoreboard bench for cdc_event_sched: stimulus pushes expected channel IDs,
// a bclk monitor pops one per b_valid and compares.
module tb_cdc_event_sched;

    localparam int NCH  = 4;
    localparam int CNTW = 3;
    localparam int IDW  = 2;

    logic           aclk = 1'b0, bclk = 1'b0;
    logic           arst = 1'b1, brst = 1'b1;
    logic [NCH-1:0] req = '0;
    logic           ovf_clr = 1'b0, boe = 1'b1;
    logic [NCH-1:0] ovf;
    logic           busy, b_valid;
    logic [IDW-1:0] b_id;

    int             n_tests = 0, n_fail = 0;
    logic [IDW-1:0] sb[$];

    cdc_event_sched #(.NCH(NCH), .CNTW(CNTW)) dut (
        .aclk(aclk), .arst(arst), .bclk(bclk), .brst(brst),
        .req(req), .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy),
        .boe(boe), .b_valid(b_valid), .b_id(b_id)
    );

    always #5 aclk = ~aclk;
    initial begin
        #3;
        forever #10 bclk = ~bclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every delivered event must match the oldest expected ID.
    always @(negedge bclk) begin
        logic [IDW-1:0] e;
        if (b_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_delivery: got id %0d expected none", b_id);
            end else begin
                e = sb.pop_front();
                if (b_id !== e) begin
                    n_fail++;
                    $display("FAIL delivery_id: got %0d expected %0d", b_id, e);
                end
            end
        end
    end

    task automatic pulse(input logic [NCH-1:0] v);
        @(negedge aclk) req = v;
        @(negedge aclk) req = '0;
    endtask

    // Wait (bounded) until all expected events are delivered and the FSM idles.
    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && k < 3000) begin
            @(negedge aclk);
            k++;
        end
        chk({name, "_pending"}, sb.size(), 0);
        chk({name, "_busy_low"}, busy, 0);
        repeat (4) @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nv;

        repeat (4) @(posedge bclk);
        @(negedge aclk);
        arst = 1'b0;
        brst = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_b_id", b_id, 0);

        // Single event on channel 2, grant-to-delivery latency in bclk cycles.
        sb.push_back(2'd2);
        pulse(4'b0100);
        for (int k = 0; k < 6 && busy !== 1'b1; k++) @(negedge aclk);
        chk("single_busy", busy, 1);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge bclk);
            #1;
            if (b_valid === 1'b1) lat = k;
        end
        chk("single_latency", lat, 3);
        drain("single");

        // Five-cycle burst on channel 1: counter absorbs it, no overflow.
        repeat (5) sb.push_back(2'd1);
        @(negedge aclk) req = 4'b0010;
        repeat (5) @(negedge aclk);
        req = '0;
        drain("burst");
        chk("burst_ovf", ovf, 0);

        // Saturation on channel 0 with delivery stalled: 1 in flight + 7 held.
        @(negedge aclk) boe = 1'b0;
        req = 4'b0001;
        repeat (9) @(negedge aclk);
        req = '0;
        chk("sat_ovf", ovf, 4'b0001);
        chk("sat_busy", busy, 1);
        ovf_clr = 1'b1;
        @(negedge aclk) ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        repeat (8) sb.push_back(2'd0);
        @(negedge bclk) boe = 1'b1;
        drain("sat");

        // boe stall mid-flight on channel 3.
        sb.push_back(2'd3);
        @(negedge aclk) begin req = 4'b1000; boe = 1'b0; end
        @(negedge aclk) req = '0;
        nv = 0;
        repeat (50) begin
            @(negedge bclk);
            if (b_valid === 1'b1) nv++;
        end
        chk("stall_no_valid", nv, 0);
        chk("stall_busy", busy, 1);
        boe = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(posedge bclk);
            #1;
            if (b_valid === 1'b1) lat = k;
        end
        chk("stall_resume", (lat >= 1 && lat <= 3), 1);
        drain("stall");

        // Joint reset while channel 1 is in flight: event abandoned.
        @(negedge aclk) begin req = 4'b0010; boe = 1'b0; end
        @(negedge aclk) req = '0;
        repeat (3) @(negedge aclk);
        chk("mid_busy", busy, 1);
        arst = 1'b1;
        brst = 1'b1;
        repeat (4) @(negedge bclk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_b_valid", b_valid, 0);
        chk("mid_rst_b_id", b_id, 0);
        @(negedge aclk) begin arst = 1'b0; brst = 1'b0; boe = 1'b1; end
        repeat (20) @(negedge bclk);
        chk("mid_no_delivery", sb.size(), 0);
        sb.push_back(2'd3);
        pulse(4'b1000);
        drain("post_rst");

        // All four channels at once from pointer 0.
        sb.push_back(2'd0); sb.push_back(2'd1);
        sb.push_back(2'd2); sb.push_back(2'd3);
        pulse(4'b1111);
        drain("rr_all");

        // Move the pointer to 3, then contend channels 0 and 3.
        sb.push_back(2'd2);
        pulse(4'b0100);
        drain("rr_ptr");
`ifdef CDC_EVENT_SCHED_PRIO_EN
        sb.push_back(2'd0); sb.push_back(2'd3);
`else
        sb.push_back(2'd3); sb.push_back(2'd0);
`endif
        pulse(4'b1001);
        drain("rr_pair");

        // Overflow set coinciding with ovf_clr: the set wins.
        @(negedge aclk) boe = 1'b0;
        req = 4'b0001;
        repeat (8) @(negedge aclk);
        ovf_clr = 1'b1;
        @(negedge aclk) begin req = '0; ovf_clr = 1'b0; end
        chk("ovf_set_wins", ovf, 4'b0001);
        ovf_clr = 1'b1;
        @(negedge aclk) ovf_clr = 1'b0;
        chk("ovf_clr2", ovf, 0);
        repeat (8) sb.push_back(2'd0);
        @(negedge bclk) boe = 1'b1;
        drain("sat2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
